// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared types for the instruction store loader
package instr_pkg;

    localparam int INSTR_W = 9;

    typedef logic [INSTR_W-1:0] mach_code_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERR
    } ld_state_t;

endpackage

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams program words into the instruction RAM and verifies an XOR checksum
module instr_loader
    import instr_pkg::*;
#(
    parameter int pc_width = 12,
    parameter int INSTR_W  = instr_pkg::INSTR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [pc_width-1:0] base_addr,
    input  logic [pc_width:0]   len,
    input  logic                in_valid,
    input  logic [INSTR_W-1:0]  in_data,
    output logic                in_ready,
    output logic                wr_en,
    output logic [pc_width-1:0] wr_addr,
    output logic [INSTR_W-1:0]  wr_data,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [pc_width:0]   words_out
);

    localparam logic [pc_width:0] CNT_ONE = {{pc_width{1'b0}}, 1'b1};

    ld_state_t           state;
    ld_state_t           state_next;
    logic [pc_width-1:0] base_q;
    logic [pc_width:0]   len_q;
    logic [pc_width:0]   count;
    mach_code_t          csum;
    logic                start_ok;
    logic                load_accept;
    logic                last_word;

    // abort outranks both a new start and a data accept in the same cycle
    assign start_ok    = start && !abort &&
                         (state == IDLE || state == DONE || state == ERR);
    assign load_accept = (state == LOAD) && in_valid && !abort;
    assign last_word   = (count == (len_q - CNT_ONE));
    assign words_out   = count;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                done  = (state == DONE);
                error = (state == ERR);
                if (start_ok) begin
                    state_next = (len != '0) ? LOAD : CHECK;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (load_accept && last_word) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) begin
                    state_next = (in_data == csum) ? DONE : ERR;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count   <= '0;
            csum    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_next;
            wr_en <= load_accept;
            if (start_ok) begin
                base_q <= base_addr;
                len_q  <= len;
                count  <= '0;
                csum   <= '0;
            end else if (load_accept) begin
                // address wraps naturally at the pc_width boundary
                wr_addr <= base_q + count[pc_width-1:0];
                wr_data <= in_data;
                csum    <= csum ^ in_data;
                count   <= count + CNT_ONE;
            end
        end
    end

endmodule
